apb_timer_irq_ctrl: RTL and testbench

- Interrupt and event stage directly downstream of the APB timer unit counters.
- Consumes the per-counter target_reached pulses and applies edge detection, per-channel event coalescing and pending/mask/clear semantics.
- Drives the interrupt lines and uDMA/event-unit pulses.
- Counts events lost while an interrupt is still pending.

---
 rtl/apb_timer_irq_ctrl.sv | 118 +++++++++++
 tb/tb_apb_timer_irq_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer_irq_ctrl.sv
// Interrupt/event stage behind the APB timer counters: edge detect, per-channel coalescing,
// pending/mask/clear and event pulses. Define APB_TIMER_IRQ_MISS_CNT_EN for missed-event counters.
module apb_timer_irq_ctrl #(
    parameter int N_CH = 2,
    parameter int CW   = 8,
    parameter int MW   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_CH-1:0]      target_reached_i,
    input  logic [N_CH-1:0]      ch_en_i,
    input  logic [N_CH-1:0]      irq_mask_i,
    input  logic [N_CH*CW-1:0]   coal_thr_i,
    input  logic [N_CH-1:0]      irq_clr_i,
    input  logic [N_CH-1:0]      miss_clr_i,
    output logic [N_CH-1:0]      pending_o,
    output logic [N_CH-1:0]      irq_o,
    output logic                 irq_any_o,
    output logic [N_CH-1:0]      event_o,
    output logic [N_CH*MW-1:0]   miss_cnt_o
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    logic [N_CH-1:0] r_trQ;
    logic [N_CH-1:0] r_event;
    logic [N_CH-1:0] w_rise;
    logic [N_CH-1:0] w_trig;
    logic [N_CH-1:0] w_pending;

    // The edge register keeps tracking the input even while a channel is disabled,
    // so re-enabling with the input already high does not fake an edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_trQ   <= '0;
            r_event <= '0;
        end else begin
            r_trQ   <= target_reached_i;
            r_event <= w_trig;
        end
    end

    assign w_rise = target_reached_i & ~r_trQ;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [CW-1:0] r_cnt;
        logic [CW:0]   w_thrEff;
        logic [CW:0]   w_cntInc;
        state_t        r_state;
        state_t        w_stateNext;

        // One extra bit so cnt+1 never wraps; a zero threshold means "every edge".
        assign w_thrEff  = (coal_thr_i[c*CW +: CW] == '0) ? (CW+1)'(1) : {1'b0, coal_thr_i[c*CW +: CW]};
        assign w_cntInc  = {1'b0, r_cnt} + (CW+1)'(1);
        assign w_trig[c] = ch_en_i[c] & w_rise[c] & (w_cntInc >= w_thrEff);

        always_ff @(posedge clk_i) begin
            if (rst_i || !ch_en_i[c]) begin
                r_cnt <= '0;
            end else if (w_rise[c]) begin
                r_cnt <= w_trig[c] ? '0 : w_cntInc[CW-1:0];
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_state <= ST_IDLE;
            end else begin
                r_state <= w_stateNext;
            end
        end

        // A trigger always wins over a coincident clear.
        always_comb begin
            w_stateNext = r_state;
            case (r_state)
                ST_IDLE:    if (w_trig[c]) w_stateNext = ST_PENDING;
                ST_PENDING: if (irq_clr_i[c] && !w_trig[c]) w_stateNext = ST_IDLE;
                default:    w_stateNext = ST_IDLE;
            endcase
        end

        assign w_pending[c] = (r_state == ST_PENDING);

`ifdef APB_TIMER_IRQ_MISS_CNT_EN
        logic [MW-1:0] r_missCnt;
        logic          w_missInc;

        assign w_missInc = w_trig[c] & (r_state == ST_PENDING) & ~irq_clr_i[c];

        always_ff @(posedge clk_i) begin
            if (rst_i || miss_clr_i[c]) begin
                r_missCnt <= '0;
            end else if (w_missInc && (r_missCnt != '1)) begin
                r_missCnt <= r_missCnt + MW'(1);
            end
        end

        assign miss_cnt_o[c*MW +: MW] = r_missCnt;
`else
        assign miss_cnt_o[c*MW +: MW] = '0;
`endif
    end

`ifndef APB_TIMER_IRQ_MISS_CNT_EN
    logic w_unused_missClr;
    assign w_unused_missClr = ^miss_clr_i;
`endif

    assign pending_o = w_pending;
    assign irq_o     = w_pending & irq_mask_i;
    assign irq_any_o = |irq_o;
    assign event_o   = r_event;

endmodule

// File: tb/tb_apb_timer_irq_ctrl.sv
// Self-checking bench for apb_timer_irq_ctrl: cycle-level behavioural model plus directed
// checks; honours APB_TIMER_IRQ_MISS_CNT_EN the same way the design does.
module tb_apb_timer_irq_ctrl;

`ifdef APB_TIMER_IRQ_MISS_CNT_EN
    localparam bit MISS_EN = 1'b1;
`else
    localparam bit MISS_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      tr, en, mask, clr, mclr;
    logic [1:0][7:0] thr;
    logic [1:0]      pending_o, irq_o, event_o;
    logic            irq_any_o;
    logic [15:0]     miss_cnt_o;

    int nCompared   = 0;
    int nMismatched = 0;

    // Model state: plain integers per channel
    int         mCnt [2];
    int         mMiss [2];
    bit [1:0]   mPend, mEvt, mPrev;

    apb_timer_irq_ctrl dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .target_reached_i (tr),
        .ch_en_i          (en),
        .irq_mask_i       (mask),
        .coal_thr_i       (thr),
        .irq_clr_i        (clr),
        .miss_clr_i       (mclr),
        .pending_o        (pending_o),
        .irq_o            (irq_o),
        .irq_any_o        (irq_any_o),
        .event_o          (event_o),
        .miss_cnt_o       (miss_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge's worth of the rules: count rising edges per channel, fire when the
    // running count reaches the effective threshold, then apply pending/miss rules.
    task automatic modelStep();
        if (rst) begin
            mPend = '0; mEvt = '0; mPrev = '0;
            for (int c = 0; c < 2; c++) begin
                mCnt[c] = 0; mMiss[c] = 0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                bit rise, trig;
                int thrE;
                rise = tr[c] && !mPrev[c];
                thrE = (thr[c] == 0) ? 1 : int'(thr[c]);
                trig = 1'b0;
                if (!en[c]) mCnt[c] = 0;
                else if (rise) begin
                    if (mCnt[c] + 1 >= thrE) begin
                        mCnt[c] = 0;
                        trig = 1'b1;
                    end else mCnt[c] = mCnt[c] + 1;
                end
                mEvt[c] = trig;
                if (MISS_EN) begin
                    if (mclr[c]) mMiss[c] = 0;
                    else if (trig && mPend[c] && !clr[c]) mMiss[c] = (mMiss[c] >= 255) ? 255 : mMiss[c] + 1;
                end
                if (trig) mPend[c] = 1'b1;
                else if (clr[c]) mPend[c] = 1'b0;
                mPrev[c] = tr[c];
            end
        end
    endtask

    // Compare process: model advances on the edge, outputs are checked 3 time units later.
    always begin
        @(posedge clk);
        modelStep();
        #3;
        checkOutput("pending", pending_o, mPend);
        checkOutput("irq", irq_o, mPend & mask);
        checkOutput("irqAny", irq_any_o, |(mPend & mask));
        checkOutput("event", event_o, mEvt);
        checkOutput("missCnt", miss_cnt_o, {mMiss[1][7:0], mMiss[0][7:0]});
    end

    task automatic cycle();
        @(posedge clk);
        #4;
    endtask

    task automatic applyStimulus(input logic [1:0] t, input logic [1:0] c, input logic [1:0] mc);
        tr   = t;
        clr  = c;
        mclr = mc;
        cycle();
    endtask

    task automatic pulse(input logic [1:0] t);
        applyStimulus(t, 2'b00, 2'b00);
        applyStimulus(2'b00, 2'b00, 2'b00);
    endtask

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int evCount;
        rst = 1'b1; tr = '0; en = 2'b11; mask = 2'b11; clr = '0; mclr = '0;
        thr[0] = 8'd1; thr[1] = 8'd1;
        repeat (3) cycle();
        checkOutput("rstPending", pending_o, 0);
        checkOutput("rstEvent", event_o, 0);
        checkOutput("rstIrqAny", irq_any_o, 0);
        checkOutput("rstMiss", miss_cnt_o, 0);
        rst = 1'b0;
        cycle();

        $display("[TB] basic trigger");
        applyStimulus(2'b01, 2'b00, 2'b00);
        checkOutput("basicPending", pending_o, 2'b01);
        checkOutput("basicIrq", irq_o, 2'b01);
        checkOutput("basicIrqAny", irq_any_o, 1);
        checkOutput("basicEvent", event_o, 2'b01);
        applyStimulus(2'b00, 2'b00, 2'b00);
        checkOutput("basicEventOnce", event_o, 2'b00);
        checkOutput("basicPendingHeld", pending_o, 2'b01);
        applyStimulus(2'b00, 2'b01, 2'b00);
        checkOutput("basicCleared", pending_o, 2'b00);

        $display("[TB] coalescing and level input");
        thr[1] = 8'd3;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(2'b10, 2'b00, 2'b00);
            checkOutput($sformatf("coalPulse%0d", i), event_o[1], (i == 3) ? 1 : 0);
            applyStimulus(2'b00, 2'b00, 2'b00);
        end
        evCount = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(2'b10, 2'b00, 2'b00);
            evCount += int'(event_o[1]);
        end
        checkOutput("levelEvents", evCount, 1);
        applyStimulus(2'b00, 2'b00, 2'b00);
        thr[1] = 8'd0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(2'b10, 2'b00, 2'b00);
            checkOutput("thrZeroEvent", event_o, 2'b10);
            applyStimulus(2'b00, 2'b00, 2'b00);
        end
        checkOutput("missAfterCoal", miss_cnt_o[15:8], MISS_EN ? 3 : 0);

        $display("[TB] clear/set race");
        applyStimulus(2'b00, 2'b10, 2'b00);
        checkOutput("raceCleared", pending_o, 2'b00);
        thr[1] = 8'd1;
        pulse(2'b10);
        checkOutput("raceSet", pending_o, 2'b10);
        applyStimulus(2'b10, 2'b10, 2'b00);
        checkOutput("racePending", pending_o, 2'b10);
        checkOutput("raceEvent", event_o, 2'b10);
        checkOutput("raceMiss", miss_cnt_o[15:8], MISS_EN ? 3 : 0);
        applyStimulus(2'b00, 2'b00, 2'b00);

        $display("[TB] mask and enable");
        mask = 2'b00;
        applyStimulus(2'b01, 2'b00, 2'b00);
        checkOutput("maskPending", pending_o, 2'b11);
        checkOutput("maskIrq", irq_o, 2'b00);
        checkOutput("maskIrqAny", irq_any_o, 0);
        applyStimulus(2'b00, 2'b00, 2'b00);
        mask = 2'b01;
        #1;
        checkOutput("unmaskIrq", irq_o, 2'b01);
        checkOutput("unmaskIrqAny", irq_any_o, 1);
        applyStimulus(2'b00, 2'b01, 2'b00);
        mask = 2'b11;
        thr[0] = 8'd4;
        for (int i = 0; i < 2; i++) begin
            pulse(2'b01);
            checkOutput("enPreCount", event_o, 2'b00);
        end
        en = 2'b10;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b01, 2'b00, 2'b00);
            checkOutput("disabledEvent", event_o, 2'b00);
            applyStimulus(2'b00, 2'b00, 2'b00);
        end
        en = 2'b11;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(2'b01, 2'b00, 2'b00);
            checkOutput($sformatf("reEnPulse%0d", i), event_o, (i == 4) ? 2'b01 : 2'b00);
            applyStimulus(2'b00, 2'b00, 2'b00);
        end

        $display("[TB] missed-event saturation");
        thr[0] = 8'd1;
        for (int i = 0; i < 300; i++) pulse(2'b01);
        checkOutput("missSat", miss_cnt_o[7:0], MISS_EN ? 255 : 0);
        applyStimulus(2'b01, 2'b00, 2'b01);
        checkOutput("missClrWins", miss_cnt_o[7:0], 0);
        checkOutput("missClrEvent", event_o, 2'b01);
        applyStimulus(2'b00, 2'b00, 2'b00);

        $display("[TB] reset mid-operation");
        thr[1] = 8'd3;
        pulse(2'b10);
        checkOutput("midPending", pending_o, 2'b11);
        tr = 2'b11;
        rst = 1'b1;
        cycle();
        checkOutput("midRstPending", pending_o, 0);
        checkOutput("midRstIrqAny", irq_any_o, 0);
        checkOutput("midRstEvent", event_o, 0);
        checkOutput("midRstMiss", miss_cnt_o, 0);
        cycle();
        rst = 1'b0;
        thr[0] = 8'd1; thr[1] = 8'd1;
        cycle();
        checkOutput("postRstEvent", event_o, 2'b11);
        checkOutput("postRstPending", pending_o, 2'b11);
        cycle();
        checkOutput("postRstHeld", event_o, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
